// File: rtl/rand_range_picker_if.sv
// Handshake bundle for rand_range_picker: request/ack from the consumer,
// byte feed from the upstream LFSR, and the ranged result.
interface rand_range_picker_if;
  logic       start;
  logic       ack;
  logic [7:0] rnd_in;
  logic       give_random;
  logic [7:0] value;
  logic       valid;
  logic       busy;
  logic       fallback_used;

  modport master (
    output start, ack, rnd_in,
    input  give_random, value, valid, busy, fallback_used
  );

  modport slave (
    input  start, ack, rnd_in,
    output give_random, value, valid, busy, fallback_used
  );
endinterface

// File: rtl/rand_range_picker.sv
// Rejection-sampling range picker with a wrapping fallback counter.
// Optional macro RAND_NO_REPEAT_EN rejects a repeat of the last value.
module rand_range_picker #(
  parameter int LIMIT     = 10,
  parameter int MAX_TRIES = 8
) (
  input  logic clock,
  input  logic reset,
  rand_range_picker_if.slave bus
);

  localparam int         W        = $clog2(LIMIT);
  localparam logic [7:0] MASK     = 8'((1 << W) - 1);
  localparam logic [8:0] LIM      = 9'(LIMIT);
  localparam logic [7:0] TOP      = 8'(LIMIT - 1);
  localparam logic [3:0] LAST_TRY = 4'(MAX_TRIES - 1);

  typedef enum logic [2:0] {
    IDLE, REQ, SAMPLE, CHECK, DONE
  } state_t;

  state_t     state, nxt;
  logic [7:0] sample;
  logic [3:0] tries;
  logic [7:0] fb_cnt;
  logic [7:0] value_q;
  logic       fb_used_q;
  logic       in_range;
  logic       repeat_hit;
  logic       accept;
  logic       last_try;
  logic       enter_done;
  logic       give_random;
  logic       valid;
  logic       busy;

`ifdef RAND_NO_REPEAT_EN
  logic [7:0] last;
  logic       has_last;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    in_range = {1'b0, sample} < LIM;
`ifdef RAND_NO_REPEAT_EN
    repeat_hit = has_last && (sample == last);
`else
    repeat_hit = 1'b0;
`endif
    accept      = in_range && !repeat_hit;
    last_try    = (tries == LAST_TRY);
    nxt         = state;
    give_random = 1'b0;
    valid       = 1'b0;
    busy        = 1'b1;
    enter_done  = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (bus.start) nxt = REQ;
      end
      REQ: begin
        give_random = 1'b1;
        nxt = SAMPLE;
      end
      SAMPLE: nxt = CHECK;
      CHECK: begin
        if (accept || last_try) begin
          nxt = DONE;
          enter_done = 1'b1;
        end else begin
          nxt = REQ;
        end
      end
      DONE: begin
        valid = 1'b1;
        if (bus.ack) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sample    <= '0;
      tries     <= '0;
      fb_cnt    <= '0;
      value_q   <= '0;
      fb_used_q <= 1'b0;
`ifdef RAND_NO_REPEAT_EN
      last      <= '0;
      has_last  <= 1'b0;
`endif
    end else begin
      if (state == SAMPLE)
        sample <= bus.rnd_in & MASK;
      if (state == CHECK && !accept && !last_try)
        tries <= tries + 4'd1;
      if (state == DONE && bus.ack)
        tries <= '0;
      if (enter_done) begin
        // Fallback path ignores the repeat filter by construction.
        value_q   <= accept ? sample : fb_cnt;
        fb_used_q <= !accept;
        fb_cnt    <= (fb_cnt == TOP) ? 8'd0 : fb_cnt + 8'd1;
`ifdef RAND_NO_REPEAT_EN
        last      <= accept ? sample : fb_cnt;
        has_last  <= 1'b1;
`endif
      end
    end
  end

  assign bus.give_random   = give_random;
  assign bus.valid         = valid;
  assign bus.busy          = busy;
  assign bus.value         = value_q;
  assign bus.fallback_used = fb_used_q;

endmodule

// File: tb/tb_rand_range_picker.sv
// Directed bench for rand_range_picker (LIMIT=10, MAX_TRIES=8).
// Checks latency, rejection, fallback, reset abort and ack/start overlap.
module tb_rand_range_picker;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  rand_range_picker_if bus ();

  rand_range_picker #(
    .LIMIT     (10),
    .MAX_TRIES (8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Issue start; feed r0 on the first sample and r1 on later ones.
  // Stops in DONE without acking.
  task automatic run_req(input logic [7:0] r0, input logic [7:0] r1,
                         output int lat, output int pulses);
    bus.rnd_in = r0;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    lat    = 1;
    pulses = 0;
    while (lat < 200) begin
      if (bus.give_random === 1'b1) begin
        pulses++;
        bus.rnd_in = (pulses == 1) ? r0 : r1;
      end
      if (bus.valid === 1'b1) break;
      tick();
      lat++;
    end
    if (lat >= 200) begin
      tests++;
      fails++;
      $display("FAIL run_req_timeout: got %0d cycles, expected valid", lat);
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.ack    = 1'b0;
    bus.rnd_in = 8'h00;
    tick();
    tick();
    chk("reset_valid", bus.valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_give", bus.give_random, 0);
    chk("reset_value", bus.value, 0);
    chk("reset_fb", bus.fallback_used, 0);
    rst_n = 1'b1;
    tick();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_idle_busy", bus.busy, 0);
  endtask

  task automatic test_basic();
    int lat, pulses;
    run_req(8'h07, 8'h07, lat, pulses);
    chk("basic_lat", lat, 4);
    chk("basic_value", bus.value, 7);
    chk("basic_fb", bus.fallback_used, 0);
    chk("basic_pulses", pulses, 1);
    tick();
    tick();
    chk("basic_hold_valid", bus.valid, 1);
    chk("basic_hold_value", bus.value, 7);
    do_ack();
    chk("basic_ack_valid", bus.valid, 0);
  endtask

  task automatic test_reject();
    int lat, pulses;
    run_req(8'h3C, 8'h05, lat, pulses);
    chk("reject_lat", lat, 7);
    chk("reject_value", bus.value, 5);
    chk("reject_pulses", pulses, 2);
    do_ack();
  endtask

  task automatic test_fallback();
    int lat, pulses;
    do_reset();
    run_req(8'hFF, 8'hFF, lat, pulses);
    chk("fb1_pulses", pulses, 8);
    chk("fb1_value", bus.value, 0);
    chk("fb1_used", bus.fallback_used, 1);
    chk("fb1_lat", lat, 4 + 7 * 3);
    do_ack();
    run_req(8'hFF, 8'hFF, lat, pulses);
    chk("fb2_value", bus.value, 1);
    chk("fb2_used", bus.fallback_used, 1);
    do_ack();
  endtask

  task automatic test_no_repeat();
    int lat, pulses;
    run_req(8'h03, 8'h03, lat, pulses);
    chk("rep_prior", bus.value, 3);
    do_ack();
    run_req(8'h03, 8'h04, lat, pulses);
`ifdef RAND_NO_REPEAT_EN
    chk("rep_value", bus.value, 4);
    chk("rep_pulses", pulses, 2);
`else
    chk("rep_value", bus.value, 3);
    chk("rep_pulses", pulses, 1);
`endif
    do_ack();
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    bus.rnd_in = 8'h09;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    chk("mid_req_give", bus.give_random, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_busy", bus.busy, 0);
    chk("mid_valid", bus.valid, 0);
    chk("mid_value", bus.value, 0);
    chk("mid_give", bus.give_random, 0);
    chk("mid_fb", bus.fallback_used, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run_req(8'h02, 8'h02, lat, pulses);
    chk("mid_after_lat", lat, 4);
    chk("mid_after_value", bus.value, 2);
    do_ack();
  endtask

  task automatic test_ack_start();
    int lat, pulses, gr;
    run_req(8'h06, 8'h06, lat, pulses);
    chk("as_value", bus.value, 6);
    bus.ack   = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.ack   = 1'b0;
    bus.start = 1'b0;
    chk("as_valid", bus.valid, 0);
    chk("as_busy", bus.busy, 0);
    gr = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.give_random === 1'b1 || bus.busy === 1'b1) gr++;
      tick();
    end
    chk("as_no_req", gr, 0);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_reject();
    test_fallback();
    test_no_repeat();
    test_reset_mid();
    test_ack_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rand_range_picker.md
RAND_RANGE_PICKER -- requirements
Module: rand_range_picker

Interface
REQ-001 Parameter LIMIT, default 10, size of the output range [0, LIMIT-1]; legal 2..256.
REQ-002 Parameter MAX_TRIES, default 8, rejected samples allowed before fallback; legal 1..15.
REQ-003 clock  input  1  single clock; all state updates on the posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request for a new ranged value.
REQ-006 ack  input  1  consumer has taken value.
REQ-007 rnd_in  input  8  random byte from the upstream LFSR generator.
REQ-008 give_random  output  1  request pulse to the upstream generator.
REQ-009 value  output  8  ranged result, zero-extended.
REQ-010 valid  output  1  value is meaningful and held.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 fallback_used  output  1  current value came from the fallback counter.

Function
REQ-013 The FSM SHALL have the states IDLE, REQ, SAMPLE, CHECK and DONE, one-hot or binary-encoded.
REQ-014 IDLE: start=1 -> REQ; start=0 -> stay; try count cleared on entry.
REQ-015 REQ: give_random=1 for exactly this one cycle -> SAMPLE; give_random=0 in all other states.
REQ-016 SAMPLE: capture sample = rnd_in & MASK, where MASK = 2^ceil(log2 LIMIT) - 1 -> CHECK.
REQ-017 CHECK: accept if sample < LIMIT (and REQ-028 when enabled) -> DONE with value = sample, fallback_used = 0.
REQ-018 CHECK reject with try count < MAX_TRIES-1: increment try count -> REQ.
REQ-019 CHECK reject with try count = MAX_TRIES-1: value = fallback counter, fallback_used = 1 -> DONE.
REQ-020 Fallback counter SHALL advance on every entry to DONE, wrapping LIMIT-1 -> 0, and be 0 after reset.
REQ-021 DONE: valid=1, with value and fallback_used held stable until ack=1 -> IDLE; valid drops the cycle after ack.
REQ-022 Minimum latency SHALL be 4 cycles from the start edge to valid; each rejection adds 3 cycles.
REQ-023 start outside IDLE, including in the same cycle as ack in DONE, SHALL be ignored, not queued.
REQ-024 ack outside DONE SHALL be ignored.

Reset
REQ-025 reset=0 SHALL immediately force IDLE, with value=0, valid=0, busy=0, give_random=0, fallback_used=0, try count=0, fallback counter=0, last-value register=0.
REQ-026 Reset asserted mid-request SHALL abandon the request; after release the block accepts a fresh start with no residual output.

Configuration
REQ-027 Macro RAND_NO_REPEAT_EN SHALL compile in the no-immediate-repeat filter.
REQ-028 With RAND_NO_REPEAT_EN defined, CHECK SHALL also reject sample equal to the last delivered value (register updated on each entry to DONE; first request after reset exempt); the fallback path bypasses this check.
REQ-029 Without RAND_NO_REPEAT_EN, the last-value register and compare SHALL be absent, and repeats are legal.

Verification (LIMIT=10, MAX_TRIES=8, unless noted)
REQ-030 start with rnd_in=8'h07 -> give_random pulse 1 cycle later; valid=1 with value=7 and fallback_used=0 on the 4th cycle after start.
REQ-031 rnd_in=8'h3C on the first sample, then 8'h05 -> first try rejected (0x0C=12), value=5 valid 7 cycles after start, exactly 2 give_random pulses.
REQ-032 rnd_in held at 8'hFF -> 8 give_random pulses, then value=0 and fallback_used=1; repeat the test -> value=1.
REQ-033 RAND_NO_REPEAT_EN: prior value=3, rnd_in=8'h03 then 8'h04 -> value=4; without the macro, the same stimulus -> value=3.
REQ-034 reset pulsed in the SAMPLE state -> all outputs 0 immediately; a following start with rnd_in=8'h02 -> value=2 after 4 cycles.
REQ-035 In DONE, ack=1 and start=1 in the same cycle -> IDLE, valid=0 the next cycle, and no give_random pulse issued.
